tx_fifo_tclk: RTL and testbench
===============================

# tx_fifo_tclk

Transmit-side source buffer in the tclk domain, directly upstream of the tclk handshake stage. Producer logic pushes 32-bit words; the block presents the oldest word as `transmit_data` with `data_avail`. It retires that word when it sees the handshake stage raise `t_rdy`, which is the cycle after the handshake stage has latched the word. Flop-array FIFO with occupancy count and sticky overflow/underflow error flags.

## Interface
- `DEPTH`, 8: number of entries; power of 2, ≥2.
- `WIDTH`, 32: data width; must match the handshake stage's `transmit_data`.
- `AW`, $clog2(DEPTH): local parameter; pointer index width.

- `tclk` input 1: transmit clock; all state on its rising edge.
- `resetb_tclk` input 1: reset, asynchronous, active-low.
- `wr_en` input 1: push request from the producer.
- `wr_data` input WIDTH: word to push.
- `wr_full` output 1: FIFO holds DEPTH words.
- `count` output AW+1: current occupancy, 0..DEPTH.
- `data_avail` output 1: FIFO non-empty; goes to the handshake stage.
- `transmit_data` output WIDTH: head word; goes to the handshake stage.
- `t_rdy` input 1: `t_rdy` from the handshake stage; used for pop detection.
- `err_clr` input 1: synchronous clear of both sticky error flags.
- `ovf_err` output 1: sticky flag; a push was attempted while full.
- `udf_err` output 1: sticky flag; a `t_rdy` rise occurred while empty.

## Operation
- **Storage**
  - DEPTH×WIDTH flop array.
  - `wr_ptr` and `rd_ptr` are AW+1 bits; index with the low AW bits; the MSB distinguishes full from empty.
- **Derived outputs**
  - `count = wr_ptr - rd_ptr`, modulo 2^(AW+1).
  - `wr_full = (count == DEPTH)`.
  - `data_avail = (count != 0)`.
  - All three are combinational from registers only; there is no input-to-output path.
- **Head word**
  - `transmit_data` is mem[rd_ptr[AW-1:0]] when non-empty, and all zeros when empty.
- **Push**
  - `push = wr_en & ~wr_full`.
  - On push: write mem[wr_ptr], then wr_ptr+1.
  - `wr_en & wr_full` drops the word and sets `ovf_err`. This holds even if a pop occurs in the same cycle: fullness is judged on the pre-edge count.
- **Pop detection**
  - Register `t_rdy_d1 <= t_rdy`.
  - `rise = t_rdy & ~t_rdy_d1`.
  - `pop = rise & data_avail`; on pop, rd_ptr+1.
  - `rise & ~data_avail` sets `udf_err`, and no pointer moves.
- **Simultaneous push and pop**
  - Both pointers advance and count is unchanged.
  - At count=1, the head becomes the newly written word.
- **Pointer wrap**
  - Pointers wrap naturally at 2^(AW+1).
  - Index wraps at DEPTH.
  - No special case at the boundary.
- **Error flags**
  - `err_clr` clears the flags.
  - If a set condition and `err_clr` occur in the same cycle, set wins.
- **Reset (asynchronous, including mid-operation)**
  - Pointers, `t_rdy_d1`, `ovf_err` and `udf_err` go to 0.
  - Stored words are discarded; the memory array needs no reset.
  - Reset values of outputs: `count`=0, `wr_full`=0, `data_avail`=0, `transmit_data`=0, `ovf_err`=0, `udf_err`=0.

## Timing
- **Push to visible:** a word pushed at edge N appears on `data_avail`/`transmit_data` after edge N; latency is 1 cycle.
- **Pop sequence:**
  - The handshake stage latches the head at edge E0 and drives `t_rdy`=1 after E0.
  - `rise` is high in cycle E0..E1; rd_ptr advances at E1.
  - The next word appears after E1.
- **Hold requirement:** the head must stay stable from the sampling edge until the pop. This is guaranteed because the handshake stage does not sample again until after `r_ack` round-trip synchronisation, at least 2 cycles later.
- **Level-high `t_rdy`:** a `t_rdy` held high for many cycles pops exactly once.
- **Back-to-back words:** `t_rdy` must drop and rise again; each rise retires one word.
- **Throughput:** at most one push and one pop per cycle.

## Test plan
- **Reset state:** drive reset, then release with no traffic → `count`=0, `data_avail`=0, `transmit_data`=0, both errors 0.
- **Single word:** push 0xDEADBEEF; pulse `t_rdy` high for 3 cycles.
  - Push → `data_avail`=1 and `transmit_data`=0xDEADBEEF next cycle.
  - Single pop one cycle after the rise → `count` 1→0; `transmit_data`=0.
- **Fill and overflow:** push 0x0..0x8 with DEPTH=8.
  - After 8 pushes → `wr_full`=1, `count`=8.
  - 9th push dropped → `ovf_err`=1.
  - `err_clr` → `ovf_err`=0.
- **Ordering and wrap:** push 20 words 0x100+i, popping continuously with `t_rdy` pulses 1-high/3-low → output order 0x100..0x113, pointers wrap twice, no errors.
- **Simultaneous push and pop:**
  - At count=1 (head 0xA), push 0xB in the rise cycle → `count` stays 1, head becomes 0xB.
  - At count=8, push and pop together → push rejected, `ovf_err`=1, `count`=7.
- **Underflow, then reset mid-operation:**
  - `t_rdy` rise while empty → `udf_err`=1, pointers unchanged.
  - Load 5 words, then assert reset asynchronously mid-cycle → all outputs return to reset values immediately.

Source files
------------

// File: rtl/tx_fifo_tclk_if.sv
// Producer / handshake-stage bundle for the tclk transmit FIFO.
interface tx_fifo_tclk_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             wr_full;
    logic [AW:0]      count;
    logic             data_avail;
    logic [WIDTH-1:0] transmit_data;
    logic             t_rdy;
    logic             err_clr;
    logic             ovf_err;
    logic             udf_err;

    // Environment side: producer and handshake stage.
    modport master (
        output wr_en, wr_data, t_rdy, err_clr,
        input  wr_full, count, data_avail, transmit_data, ovf_err, udf_err
    );

    // FIFO side.
    modport slave (
        input  wr_en, wr_data, t_rdy, err_clr,
        output wr_full, count, data_avail, transmit_data, ovf_err, udf_err
    );
endinterface

// File: rtl/tx_fifo_tclk.sv
// Transmit source FIFO in the tclk domain; retires the head word on each
// rising edge of the handshake stage's t_rdy.
module tx_fifo_tclk #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic          tclk,
    input  logic          resetb_tclk,
    tx_fifo_tclk_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             t_rdy_d1;
    logic             ovf_err;
    logic             udf_err;

    logic [PW-1:0]    count_c;
    logic             full_c;
    logic             avail_c;
    logic             rise_c;
    logic             push_c;
    logic             pop_c;
    logic             ovf_set_c;
    logic             udf_set_c;

    // Occupancy, push/pop qualification and error set conditions.
    always_comb begin
        count_c   = wr_ptr - rd_ptr;
        full_c    = (count_c == PW'(DEPTH));
        avail_c   = (count_c != '0);
        rise_c    = bus.t_rdy & ~t_rdy_d1;
        push_c    = bus.wr_en & ~full_c;
        pop_c     = rise_c & avail_c;
        ovf_set_c = bus.wr_en & full_c;
        udf_set_c = rise_c & ~avail_c;
    end

    // Storage array; contents are meaningless outside [rd_ptr, wr_ptr).
    always_ff @(posedge tclk) begin
        if (push_c) begin
            mem[wr_ptr[AW-1:0]] <= bus.wr_data;
        end
    end

    // Pointers and t_rdy edge-detect history.
    always_ff @(posedge tclk or negedge resetb_tclk) begin
        if (!resetb_tclk) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            t_rdy_d1 <= 1'b0;
        end else begin
            t_rdy_d1 <= bus.t_rdy;
            if (push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Sticky error flags; a set in the same cycle as a clear wins.
    always_ff @(posedge tclk or negedge resetb_tclk) begin
        if (!resetb_tclk) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (ovf_set_c) begin
                ovf_err <= 1'b1;
            end else if (bus.err_clr) begin
                ovf_err <= 1'b0;
            end
            if (udf_set_c) begin
                udf_err <= 1'b1;
            end else if (bus.err_clr) begin
                udf_err <= 1'b0;
            end
        end
    end

    // Outputs derived from registers only; head reads as zero when empty.
    assign bus.count         = count_c;
    assign bus.wr_full       = full_c;
    assign bus.data_avail    = avail_c;
    assign bus.transmit_data = avail_c ? mem[rd_ptr[AW-1:0]] : '0;
    assign bus.ovf_err       = ovf_err;
    assign bus.udf_err       = udf_err;
endmodule

// File: tb/tb_tx_fifo_tclk.sv
// Scoreboard bench for tx_fifo_tclk: stimulus queues expected head words,
// a negedge monitor checks the presented head and retires it on each pop.
module tb_tx_fifo_tclk;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 32;

    logic tclk;
    logic resetb_tclk;

    tx_fifo_tclk_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    tx_fifo_tclk #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .tclk        (tclk),
        .resetb_tclk (resetb_tclk),
        .bus         (bus)
    );

    initial tclk = 1'b0;
    always #5 tclk = ~tclk;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    int m_cnt    = 0;
    int m_pops   = 0;
    int obs_pops = 0;
    logic m_prev_t = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, note the expected effect, and return just after the edge.
    task automatic step(input logic we, input logic [31:0] wd, input logic tr, input logic ec);
        logic rise;
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.t_rdy   = tr;
        bus.err_clr = ec;
        rise = tr & ~m_prev_t;
        if (we && m_cnt < int'(DEPTH)) begin
            exp_q.push_back(wd);
            m_cnt++;
        end
        if (rise && m_cnt > 0 && !(we && m_cnt == 1 && exp_q.size() == 1 && 0)) begin
            m_cnt--;
            m_pops++;
        end
        m_prev_t = tr;
        @(posedge tclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // Monitor: head word must match the scoreboard front; a t_rdy rise retires it.
    logic mon_prev_t = 1'b0;
    always @(negedge tclk) begin
        if (!resetb_tclk) begin
            mon_prev_t = 1'b0;
        end else begin
            if (bus.data_avail) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL head_unexpected: got 0x%0h expected no word at %0t", bus.transmit_data, $time);
                end else begin
                    check("head_word", bus.transmit_data, exp_q[0]);
                    if (bus.t_rdy && !mon_prev_t) begin
                        void'(exp_q.pop_front());
                        obs_pops++;
                    end
                end
            end else begin
                check("empty_head_zero", bus.transmit_data, 32'h0);
            end
            mon_prev_t = bus.t_rdy;
        end
    end

    task automatic check_state(input string tag, input int cnt, input logic full,
                               input logic avail, input logic ovf, input logic udf);
        check({tag, "_count"},   32'(bus.count),      32'(cnt));
        check({tag, "_full"},    32'(bus.wr_full),    32'(full));
        check({tag, "_avail"},   32'(bus.data_avail), 32'(avail));
        check({tag, "_ovf"},     32'(bus.ovf_err),    32'(ovf));
        check({tag, "_udf"},     32'(bus.udf_err),    32'(udf));
    endtask

    initial begin
        resetb_tclk = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        bus.t_rdy   = 1'b0;
        bus.err_clr = 1'b0;
        repeat (3) @(posedge tclk);
        #1;
        resetb_tclk = 1'b1;
        @(posedge tclk);
        #1;

        // Reset state
        check_state("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_tdata", bus.transmit_data, 32'h0);

        // Single word, t_rdy held high 3 cycles pops once
        step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        check_state("single_push", 1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("single_tdata", bus.transmit_data, 32'hDEADBEEF);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check_state("single_pop", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("single_pop_tdata", bus.transmit_data, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check_state("level_high", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Fill, overflow, clear; then push+pop at full
        for (int i = 0; i < 8; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        check_state("fill", 8, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h8, 1'b0, 1'b0);
        check_state("ovf", 8, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check_state("ovf_clr", 8, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h99, 1'b1, 1'b0);
        check_state("full_push_pop", 7, 1'b0, 1'b1, 1'b1, 1'b0);
        check("full_push_pop_head", bus.transmit_data, 32'h1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            step(1'b0, 32'h0, 1'b0, 1'b0);
        end
        check_state("drain", 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Ordering and pointer wrap: 20 words, t_rdy 1-high/3-low
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
            step(1'b0, 32'h0, 1'b0, 1'b0);
            step(1'b0, 32'h0, 1'b1, 1'b0);
            step(1'b0, 32'h0, 1'b0, 1'b0);
        end
        check_state("wrap", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("wrap_queue_empty", 32'(exp_q.size()), 32'h0);

        // Push in the rise cycle at count=1: head becomes the new word
        step(1'b1, 32'hA, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'hB, 1'b1, 1'b0);
        check_state("swap", 1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("swap_head", bus.transmit_data, 32'hB);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check_state("swap_drain", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        // Underflow; set wins over a simultaneous clear
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check_state("udf", 0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check_state("udf_set_wins", 0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check_state("udf_clr", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h300, 1'b0, 1'b0);
        check_state("after_udf_push", 1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("after_udf_head", bus.transmit_data, 32'h300);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);

        // Load 5 words, then asynchronous reset mid-cycle
        for (int i = 0; i < 5; i++) step(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'h0, 1'b0, 1'b1);
        check_state("loaded", 6, 1'b0, 1'b1, 1'b0, 1'b0);
        #3;
        resetb_tclk = 1'b0;
        bus.wr_en   = 1'b0;
        bus.err_clr = 1'b0;
        exp_q.delete();
        m_cnt    = 0;
        m_prev_t = 1'b0;
        #1;
        check_state("async_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("async_reset_tdata", bus.transmit_data, 32'h0);
        @(posedge tclk);
        #1;
        resetb_tclk = 1'b1;
        idle(2);
        check_state("post_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);

        check("total_pops", 32'(obs_pops), 32'(m_pops));
        check("pop_count_hand", 32'(obs_pops), 32'd32);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
